// File: rtl/axis_boxcar_filter_pkg.sv
// Shared defaults for the boxcar filter slice.
// Widths of the block's own datapath are derived inside the block itself.
package axis_boxcar_filter_pkg;

    localparam int BOXCAR_DATA_W_DEFAULT = 16;
    localparam int BOXCAR_ADDR_W_DEFAULT = 10;

endpackage

// File: rtl/axis_boxcar_ram.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read.
// An address read and written in the same cycle returns the previous contents.
module axis_boxcar_ram
    import axis_boxcar_filter_pkg::*;
#(
    parameter int DATA_W = BOXCAR_DATA_W_DEFAULT,
    parameter int ADDR_W = BOXCAR_ADDR_W_DEFAULT
) (
    input  logic              aclk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge aclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_boxcar_filter.sv
// Streaming moving-sum filter over the last N = cfg_data + 1 accepted samples.
// Emits one exact, full-precision signed sum per accepted input sample.
module axis_boxcar_filter
    import axis_boxcar_filter_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = BOXCAR_DATA_W_DEFAULT,
    parameter int ADDR_WIDTH       = BOXCAR_ADDR_W_DEFAULT
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic [ADDR_WIDTH-1:0]                cfg_data,
    output logic                                 s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0]          s_axis_tdata,
    input  logic                                 s_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic [AXIS_TDATA_WIDTH+ADDR_WIDTH-1:0] m_axis_tdata,
    output logic                                 m_axis_tvalid
);

    localparam int SUM_W  = AXIS_TDATA_WIDTH + ADDR_WIDTH;
    localparam int EXT_W  = ADDR_WIDTH;
    localparam int FILL_W = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
    localparam logic [FILL_W-1:0]     FILL_ONE = 1;

    logic                        enbl;
    logic [ADDR_WIDTH-1:0]       cfg_reg;
    logic [ADDR_WIDTH-1:0]       wr_ptr;
    logic [ADDR_WIDTH-1:0]       rd_ptr;
    logic [FILL_W-1:0]           fill;
    logic [FILL_W-1:0]           win_len;
    logic signed [SUM_W-1:0]     acc;
    logic signed [SUM_W-1:0]     acc_next;
    logic signed [SUM_W-1:0]     x_ext;
    logic signed [SUM_W-1:0]     old_ext;
    logic [AXIS_TDATA_WIDTH-1:0] ram_rdata;
    logic [AXIS_TDATA_WIDTH-1:0] old_sample;
    logic                        flush;
    logic                        accept;
    logic                        window_full;

    // Valid/ready: a beat transfers on a rising aclk edge where valid & ready are
    // both high; a source holds valid and data stable until that edge, and ready
    // never depends on the source's valid.
    assign flush         = (cfg_data != cfg_reg);
    assign s_axis_tready = enbl & ~flush & (~m_axis_tvalid | m_axis_tready);
    assign accept        = s_axis_tvalid & s_axis_tready;

    assign win_len     = {1'b0, cfg_reg} + FILL_ONE;
    assign window_full = (fill == win_len);

    // wr_ptr - (cfg_reg + 1) modulo the depth, i.e. the sample leaving the window.
    assign rd_ptr = wr_ptr + ~cfg_reg;

    assign old_sample = window_full ? ram_rdata : '0;
    assign x_ext      = {{EXT_W{s_axis_tdata[AXIS_TDATA_WIDTH-1]}}, s_axis_tdata};
    assign old_ext    = {{EXT_W{old_sample[AXIS_TDATA_WIDTH-1]}}, old_sample};
    assign acc_next   = acc + x_ext - old_ext;

    axis_boxcar_ram #(
        .DATA_W (AXIS_TDATA_WIDTH),
        .ADDR_W (ADDR_WIDTH)
    ) u_delay_line (
        .aclk  (aclk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (s_axis_tdata),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            enbl          <= 1'b0;
            cfg_reg       <= '0;
            wr_ptr        <= '0;
            fill          <= '0;
            acc           <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            enbl <= 1'b1;
            if (flush) begin
                acc     <= '0;
                fill    <= '0;
                cfg_reg <= cfg_data;
            end else if (accept) begin
                acc    <= acc_next;
                wr_ptr <= wr_ptr + PTR_ONE;
                if (!window_full) begin
                    fill <= fill + FILL_ONE;
                end
            end

            if (accept) begin
                m_axis_tdata  <= acc_next;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_boxcar_filter.sv
// Directed and randomized bench for axis_boxcar_filter with a reference
// window-sum model feeding an expected-output queue.
module tb_axis_boxcar_filter;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int SW = DW + AW;

    logic          aclk;
    logic          aresetn;
    logic [AW-1:0] cfg_data;
    logic          s_tready;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          m_tready;
    logic [SW-1:0] m_tdata;
    logic          m_tvalid;

    int tests = 0;
    int fails = 0;
    int bp_mode = 0;

    logic [SW-1:0] exp_q[$];
    int            hist[$];
    int            model_n = 1;

    logic [SW-1:0] held_data;
    logic          held_v = 1'b0;

    axis_boxcar_filter #(
        .AXIS_TDATA_WIDTH (DW),
        .ADDR_WIDTH       (AW)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_data      (cfg_data),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid)
    );

    // ---------------- clock ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input longint got, input longint exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain sum of the last model_n samples since the last flush.
    task automatic model_accept(input int x);
        longint s;
        int     lo;
        hist.push_back(x);
        lo = hist.size() - model_n;
        if (lo < 0) lo = 0;
        s = 0;
        for (int i = lo; i < hist.size(); i++) s += hist[i];
        exp_q.push_back(SW'(s));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge aclk) begin
        if (!aresetn) begin
            held_v <= 1'b0;
        end else begin
            if (held_v && m_tvalid) begin
                check("stall_stable", longint'($signed(m_tdata)), longint'($signed(held_data)));
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    check("out_data", longint'($signed(m_tdata)), longint'($signed(exp_q.pop_front())));
                end
                held_v <= 1'b0;
            end else if (m_tvalid) begin
                held_v    <= 1'b1;
                held_data <= m_tdata;
            end else begin
                held_v <= 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge aclk);
        #1;
        if (bp_mode == 1) m_tready = ~m_tready;
        else if (bp_mode == 2) m_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int x);
        int guard;
        guard    = 0;
        s_tvalid = 1'b1;
        s_tdata  = DW'(x);
        forever begin
            @(negedge aclk);
            if (s_tready) begin
                model_accept(x);
                tick();
                break;
            end
            guard++;
            if (guard > 100) begin
                check("send_timeout", guard, 0);
                tick();
                break;
            end
            tick();
        end
        s_tvalid = 1'b0;
    endtask

    task automatic set_cfg(input int c);
        if (AW'(c) != cfg_data) begin
            hist.delete();
        end
        cfg_data = AW'(c);
        model_n  = c + 1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        aresetn  = 1'b0;
        cfg_data = '0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;

        // Reset and enable
        repeat (3) begin
            @(negedge aclk);
            check("rst_m_tvalid", m_tvalid, 0);
            check("rst_s_tready", s_tready, 0);
            check("rst_m_tdata", m_tdata, 0);
        end
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        check("ready_first_cycle", s_tready, 0);
        check("valid_after_release", m_tvalid, 0);
        @(negedge aclk);
        check("ready_second_cycle", s_tready, 1);
        tick();

        // Step response, N = 4
        set_cfg(3);
        for (int i = 0; i < 8; i++) send(100);

        // Signed full depth, N = 16
        set_cfg(15);
        for (int i = 0; i < 20; i++) send(-32768);

        // Backpressure, N = 2, downstream ready alternating
        set_cfg(1);
        bp_mode = 1;
        for (int i = 1; i <= 4; i++) send(i);
        bp_mode = 0;
        m_tready = 1'b1;
        repeat (3) tick();

        // Window change mid-stream
        set_cfg(3);
        for (int i = 0; i < 6; i++) send(10);
        set_cfg(0);
        @(negedge aclk);
        check("flush_ready_low", s_tready, 0);
        tick();
        @(negedge aclk);
        check("after_flush_ready", s_tready, 1);
        tick();
        for (int i = 0; i < 4; i++) send(10);

        // Pointer wrap, N = 3, ramp
        set_cfg(2);
        for (int k = 0; k <= 40; k++) send(k);

        // Random data with random downstream stalls, N = 6
        set_cfg(5);
        bp_mode = 2;
        for (int i = 0; i < 30; i++) send(int'($urandom_range(0, 65535)) - 32768);
        bp_mode = 0;
        m_tready = 1'b1;
        repeat (4) tick();

        // Reset mid-stream drops the pending output
        m_tready = 1'b0;
        send(5);
        #1 aresetn = 1'b0;
        exp_q.delete();
        tick();
        @(negedge aclk);
        check("midreset_m_tvalid", m_tvalid, 0);
        check("midreset_s_tready", s_tready, 0);
        tick();
        aresetn  = 1'b1;
        m_tready = 1'b1;
        hist.delete();
        send(7);
        send(8);
        send(9);

        // Drain and confirm nothing is left outstanding
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_boxcar_filter.md
# axis_boxcar_filter

Streaming moving-sum (boxcar) filter placed directly downstream of the zero-order-hold interpolator. It smooths the stair-step held samples by summing the most recent N accepted samples, with N run-time configurable. It consumes the interpolator's AXI4-Stream output and emits one full-precision sum per input sample.

## Interface

**Parameters**
- AXIS_TDATA_WIDTH, 16: width of the signed two's-complement input sample.
- ADDR_WIDTH, 10: log2 of the delay-line depth. Maximum window length is 2^ADDR_WIDTH.

**Ports**
- aclk, input, 1: clock.
- aresetn, input, 1: reset; synchronous, active-low.
- cfg_data, input, ADDR_WIDTH: window length minus one, so N = cfg_data + 1 (range 1..2^ADDR_WIDTH).
- s_axis_tready, output, 1: input ready.
- s_axis_tdata, input, AXIS_TDATA_WIDTH: signed input sample.
- s_axis_tvalid, input, 1: input valid.
- m_axis_tready, input, 1: output ready.
- m_axis_tdata, output, AXIS_TDATA_WIDTH+ADDR_WIDTH: signed moving sum.
- m_axis_tvalid, output, 1: output valid.

## Operation

**State**
- Delay line: 2^ADDR_WIDTH × AXIS_TDATA_WIDTH. Written synchronously, read combinationally (distributed RAM). Contents are not reset.
- Write pointer wr_ptr (ADDR_WIDTH bits): wraps modulo 2^ADDR_WIDTH.
- Fill counter fill (ADDR_WIDTH+1 bits): saturates at N.
- Accumulator acc (AXIS_TDATA_WIDTH+ADDR_WIDTH bits, signed).
- Enable flag enbl.
- Registered copy of cfg_data, cfg_reg.

**Accept**
- A sample is accepted when s_axis_tvalid & s_axis_tready.
- old = buffer[wr_ptr − N] (modulo 2^ADDR_WIDTH) when fill == N, else 0.
- acc_next = acc + sext(x) − sext(old).
- buffer[wr_ptr] ← x; wr_ptr++; fill++ while fill < N.
- Output register loads acc_next and m_axis_tvalid is set.

**Handshake and arithmetic**
- s_axis_tready = enbl & ~flush & (~m_axis_tvalid | m_axis_tready). A single output register gives full throughput: one sample per cycle when downstream is always ready.
- m_axis_tvalid clears when m_axis_tready is high and no new sample is accepted in the same cycle.
- Arithmetic is exact: N ≤ 2^ADDR_WIDTH samples of AXIS_TDATA_WIDTH bits cannot overflow the accumulator width. No rounding or truncation is applied.

**Window change**
- When cfg_data != cfg_reg, a one-cycle flush occurs: acc ← 0, fill ← 0, cfg_reg ← cfg_data, and s_axis_tready is low for that cycle.
- wr_ptr is kept.
- A pending output stays valid until it is taken.
- When N = 2^ADDR_WIDTH, wr_ptr − N == wr_ptr, so the read of the old sample must occur before the write in the same cycle.

## Timing

- Reset values: m_axis_tvalid 0, m_axis_tdata 0, s_axis_tready 0, acc 0, fill 0, wr_ptr 0, enbl 0, cfg_reg 0.
- enbl is set on the first cycle after aresetn deasserts, so s_axis_tready rises one cycle after reset release.
- Latency: one cycle. Sample accepted at edge k, sum visible on m_axis_tdata with m_axis_tvalid high after edge k.
- Backpressure: while m_axis_tvalid & ~m_axis_tready, s_axis_tready is low and m_axis_tdata is held stable.
- Simultaneous accept and output-take in one cycle: the register reloads and m_axis_tvalid stays high.
- Reset mid-stream: all state returns to reset values in the same cycle and any output in flight is dropped. Buffer contents become don't-care because fill is 0.
- First N outputs after reset or flush are partial sums of 1..N samples.

## Structure

- Shared package holds no block-specific typedefs. The sign-extension widths are local parameters derived from AXIS_TDATA_WIDTH and ADDR_WIDTH.
- One natural sub-module: axis_boxcar_ram, a parameterized simple dual-port distributed RAM (synchronous write, asynchronous read). It is reusable by other delay-line stages.

## Test plan

- Reset and enable: hold aresetn low for 3 cycles, then release → m_axis_tvalid = 0 throughout, s_axis_tready = 0 in the first cycle after release and 1 in the second.
- Step response: cfg_data = 3, inputs 100 ×8 with ready always high → outputs 100, 200, 300, 400, 400, 400, 400, 400, each one cycle after its input.
- Signed and full depth: ADDR_WIDTH = 4, cfg_data = 15, inputs −32768 ×20 → output saturates at −524288 from the 16th output on, with no wrap.
- Backpressure: cfg_data = 1, inputs 1, 2, 3, 4, m_axis_tready toggled 1010… → outputs 1, 3, 5, 7, none lost or duplicated, m_axis_tdata stable while stalled.
- Window change: cfg_data = 3 with steady input 10; after 6 samples switch to cfg_data = 0 → one cycle with s_axis_tready low, then outputs 10, 10, ….
- Pointer wrap: ADDR_WIDTH = 4, cfg_data = 2, ramp 0..40 → each output equals 3k−3 for input k ≥ 2 across wr_ptr wrap-around.
